pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage controller for the pipelined SAD datapath. It owns the program counter register and decides its next value every cycle: sequential advance, branch/jump-register redirect from EX, jump from ID, load-use stall hold, instruction-memory wait, or halt. It also drives the IF/ID write-enable and the IF/ID and ID/EX flush controls that accompany each redirect. It sits between the hazard/branch logic and instruction memory.

## Interface
Parameters:
- RESET_ADDR, 32'h00000000: PC value loaded by reset.
- PC_INC, 4: sequential increment in bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- imem_ready  input  1  instruction memory has valid data for `pc` this cycle.
- stall_id  input  1  load-use hazard; hold PC and IF/ID.
- jump_id  input  1  J/JAL decoded in ID.
- jump_target_id  input  32  jump destination.
- redirect_ex  input  1  taken branch or JR resolved in EX.
- redirect_target_ex  input  32  EX redirect destination.
- halt_req  input  1  end-of-program instruction decoded in ID.
- pc  output  32  current fetch address (registered).
- pc_plus4  output  32  pc + PC_INC, modulo 2^32 (combinational).
- if_id_write  output  1  IF/ID register load enable.
- if_id_flush  output  1  zero the IF/ID register.
- id_ex_flush  output  1  zero the ID/EX register.
- halted  output  1  high in HALT.
- misalign  output  1  sticky: a redirect target had nonzero bits [1:0].

## Operation
- States: BOOT, RUN, WAIT, HALT.
- While rst=0 at an edge: pc=RESET_ADDR, state=BOOT, pend_valid=0, misalign=0, halted=0. During reset cycles outputs are if_id_write=0, if_id_flush=1, id_ex_flush=1.
- BOOT: one cycle. pc holds, if_id_write=0, if_id_flush=1. Next state is RUN.
- RUN, evaluated in this priority order:
  1. redirect_ex: pc<=target&~3, if_id_flush=1, id_ex_flush=1. Overrides stall_id, jump_id, halt_req, and imem_ready=0.
  2. stall_id: pc holds, if_id_write=0, no flush. jump_id and halt_req are ignored (re-presented after the stall).
  3. halt_req: go to HALT, pc holds, if_id_flush=1.
  4. jump_id: pc<=target&~3, if_id_flush=1.
  5. imem_ready=0: pc holds, if_id_write=0, go to WAIT.
  6. Otherwise: pc<=pc_plus4, if_id_write=1.
- WAIT: pc holds, if_id_write=0.
  - redirect_ex latches pend_target=target&~3 and sets pend_valid=1. A later redirect overwrites the earlier one.
  - On imem_ready=1: if pend_valid, pc<=pend_target, if_id_flush=1, pend_valid<=0. Otherwise pc<=pc_plus4, if_id_write=1. Return to RUN.
  - redirect_ex in the same cycle as imem_ready=1 is applied directly, with priority over pend_target.
- HALT: pc frozen, if_id_write=0, halted=1. All inputs are ignored; only reset exits HALT.
- Alignment: any accepted redirect whose target[1:0]≠0 sets misalign (sticky until reset); the PC still loads target&~3.
- Wrap-around: pc=32'hFFFFFFFC advancing sequentially gives 32'h00000000, with no flag.

## Timing
- pc changes only at rising edges. A redirect or jump accepted in cycle N appears on pc in cycle N+1.
- if_id_write, if_id_flush, and id_ex_flush are combinational (Mealy) from the current state and inputs, valid in the same cycle.
- Sequential fetch throughput is 1 PC per cycle while imem_ready=1.
- Branch penalty is 2 flushed slots (IF/ID and ID/EX). Jump penalty is 1 slot.
- halted rises the cycle after halt_req is accepted.
- Reset asserted mid-operation, in any state including HALT or WAIT with pend_valid: the next edge restores reset values. The pending redirect is discarded.

## Structure
- Shared package pc_ctrl_pkg:
  - state enum {BOOT, RUN, WAIT, HALT}
  - PC_INC default
  - ALIGN_MASK = 32'hFFFFFFFC
  - flush/select encoding used by the hazard unit
- One combinational sub-module, pc_next_sel: the priority mux producing next_pc plus the write/flush controls from the state and inputs.
- pc_sequencer holds the pc, state, pend_valid/pend_target, and misalign registers.

## Test plan
- Reset and boot: hold rst=0 for 3 cycles, then release with imem_ready=1. Required: pc=0 during reset and the BOOT cycle, then 4, 8, 12; if_id_flush=1 only during reset and BOOT.
- Branch over stall: at pc=0x20, assert redirect_ex with target 0x100 and stall_id=1 together. Required: next pc=0x100, if_id_flush=1 and id_ex_flush=1 in that cycle, pc not held.
- Stall then jump: stall_id=1 for 2 cycles at pc=0x40 with jump_id present, then stall_id=0 and jump_id=1 to 0x80. Required: pc stays 0x40 for 2 cycles, if_id_write=0, then pc=0x80 with if_id_flush=1.
- Memory wait with pending redirect: imem_ready=0 at pc=0x10; redirect to 0x200 arrives in WAIT; imem_ready=1 two cycles later. Required: pc holds 0x10, then becomes 0x200 with if_id_flush=1 and pend cleared.
- Halt and misalign: redirect to 0x103 sets misalign=1 and pc=0x100. Then halt_req at pc=0x104. Required: halted=1 and pc frozen for 10 cycles despite jump_id/redirect_ex; rst=0 clears halted and misalign and sets pc=0.
- Wrap: force pc to 0xFFFFFFFC via redirect, then run sequentially. Required: next pc=0x00000000.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package pc_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      HALT = 2'd3
   } state_t;

   // Next-PC source selected by the priority mux.
   typedef enum logic [2:0] {
      SEL_HOLD = 3'd0,
      SEL_SEQ  = 3'd1,
      SEL_EX   = 3'd2,
      SEL_JUMP = 3'd3,
      SEL_PEND = 3'd4
   } pc_sel_t;

   localparam logic [31:0] PC_INC_DEFAULT = 32'd4;
   localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for the next PC plus IF/ID and ID/EX pipeline controls.
module pc_next_sel
   import pc_ctrl_pkg::*;
(
   input  logic        i_rst_n,
   input  state_t      i_state,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pc_plus4,
   input  logic        i_pend_valid,
   input  logic [31:0] i_pend_target,
   input  logic        i_imem_ready,
   input  logic        i_stall_id,
   input  logic        i_jump_id,
   input  logic [31:0] i_jump_target_id,
   input  logic        i_redirect_ex,
   input  logic [31:0] i_redirect_target_ex,
   input  logic        i_halt_req,
   output logic [31:0] o_next_pc,
   output state_t      o_next_state,
   output logic        o_if_id_write,
   output logic        o_if_id_flush,
   output logic        o_id_ex_flush,
   output logic        o_pend_load,
   output logic        o_pend_clear,
   output logic        o_misalign_set
);

   pc_sel_t w_sel;

   // Next-state, PC source and Mealy pipeline controls in priority order.
   always_comb begin
      w_sel          = SEL_HOLD;
      o_next_state   = i_state;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_flush  = 1'b0;
      o_pend_load    = 1'b0;
      o_pend_clear   = 1'b0;
      o_misalign_set = 1'b0;
      if (!i_rst_n) begin
         o_if_id_flush = 1'b1;
         o_id_ex_flush = 1'b1;
      end else begin
         case (i_state)
            BOOT: begin
               o_if_id_flush = 1'b1;
               o_next_state  = RUN;
            end
            RUN: begin
               if (i_redirect_ex) begin
                  w_sel          = SEL_EX;
                  o_if_id_flush  = 1'b1;
                  o_id_ex_flush  = 1'b1;
                  o_misalign_set = |i_redirect_target_ex[1:0];
               end else if (i_stall_id) begin
                  w_sel = SEL_HOLD;
               end else if (i_halt_req) begin
                  o_next_state  = HALT;
                  o_if_id_flush = 1'b1;
               end else if (i_jump_id) begin
                  w_sel          = SEL_JUMP;
                  o_if_id_flush  = 1'b1;
                  o_misalign_set = |i_jump_target_id[1:0];
               end else if (!i_imem_ready) begin
                  o_next_state = WAIT;
               end else begin
                  w_sel         = SEL_SEQ;
                  o_if_id_write = 1'b1;
               end
            end
            WAIT: begin
               if (i_imem_ready) begin
                  o_next_state = RUN;
                  o_pend_clear = 1'b1;
                  if (i_redirect_ex) begin
                     w_sel          = SEL_EX;
                     o_if_id_flush  = 1'b1;
                     o_id_ex_flush  = 1'b1;
                     o_misalign_set = |i_redirect_target_ex[1:0];
                  end else if (i_pend_valid) begin
                     w_sel         = SEL_PEND;
                     o_if_id_flush = 1'b1;
                  end else begin
                     w_sel         = SEL_SEQ;
                     o_if_id_write = 1'b1;
                  end
               end else if (i_redirect_ex) begin
                  // Redirect is consumed now (wrong-path ID/EX squashed); PC load deferred until memory is ready.
                  o_pend_load    = 1'b1;
                  o_if_id_flush  = 1'b1;
                  o_id_ex_flush  = 1'b1;
                  o_misalign_set = |i_redirect_target_ex[1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Next-PC data mux driven by the selected source.
   always_comb begin
      case (w_sel)
         SEL_SEQ:  o_next_pc = i_pc_plus4;
         SEL_EX:   o_next_pc = align_pc(i_redirect_target_ex);
         SEL_JUMP: o_next_pc = align_pc(i_jump_target_id);
         SEL_PEND: o_next_pc = i_pend_target;
         default:  o_next_pc = i_pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: program counter, FSM state, pending redirect and misalign flag.
module pc_sequencer
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] PC_INC     = PC_INC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ready,
   input  logic        stall_id,
   input  logic        jump_id,
   input  logic [31:0] jump_target_id,
   input  logic        redirect_ex,
   input  logic [31:0] redirect_target_ex,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        halted,
   output logic        misalign
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_pend_valid;
   logic [31:0] r_pend_target;
   logic        r_misalign;

   state_t      w_next_state;
   logic [31:0] w_next_pc;
   logic [31:0] w_pc_plus4;
   logic        w_pend_load;
   logic        w_pend_clear;
   logic        w_misalign_set;

   assign w_pc_plus4 = r_pc + PC_INC;

   pc_next_sel u_next_sel (
      .i_rst_n              (rst),
      .i_state              (r_state),
      .i_pc                 (r_pc),
      .i_pc_plus4           (w_pc_plus4),
      .i_pend_valid         (r_pend_valid),
      .i_pend_target        (r_pend_target),
      .i_imem_ready         (imem_ready),
      .i_stall_id           (stall_id),
      .i_jump_id            (jump_id),
      .i_jump_target_id     (jump_target_id),
      .i_redirect_ex        (redirect_ex),
      .i_redirect_target_ex (redirect_target_ex),
      .i_halt_req           (halt_req),
      .o_next_pc            (w_next_pc),
      .o_next_state         (w_next_state),
      .o_if_id_write        (if_id_write),
      .o_if_id_flush        (if_id_flush),
      .o_id_ex_flush        (id_ex_flush),
      .o_pend_load          (w_pend_load),
      .o_pend_clear         (w_pend_clear),
      .o_misalign_set       (w_misalign_set)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= BOOT;
      else      r_state <= w_next_state;
   end

   // PC, pending-redirect and sticky misalign registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc          <= RESET_ADDR;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_pc <= w_next_pc;
         if (w_pend_load) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= align_pc(redirect_target_ex);
         end else if (w_pend_clear) begin
            r_pend_valid  <= 1'b0;
         end
         if (w_misalign_set) r_misalign <= 1'b1;
      end
   end

   assign pc       = r_pc;
   assign pc_plus4 = w_pc_plus4;
   assign halted   = (r_state == HALT);
   assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ready;
   logic        stall_id;
   logic        jump_id;
   logic [31:0] jump_target_id;
   logic        redirect_ex;
   logic [31:0] redirect_target_ex;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        halted;
   logic        misalign;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_sequencer #(
      .RESET_ADDR (32'h0000_0000),
      .PC_INC     (32'd4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .imem_ready         (imem_ready),
      .stall_id           (stall_id),
      .jump_id            (jump_id),
      .jump_target_id     (jump_target_id),
      .redirect_ex        (redirect_ex),
      .redirect_target_ex (redirect_target_ex),
      .halt_req           (halt_req),
      .pc                 (pc),
      .pc_plus4           (pc_plus4),
      .if_id_write        (if_id_write),
      .if_id_flush        (if_id_flush),
      .id_ex_flush        (id_ex_flush),
      .halted             (halted),
      .misalign           (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic redir(input logic [31:0] tgt);
      redirect_ex        = 1'b1;
      redirect_target_ex = tgt;
      tick();
      redirect_ex        = 1'b0;
   endtask

   initial begin
      rst                = 1'b0;
      imem_ready         = 1'b1;
      stall_id           = 1'b0;
      jump_id            = 1'b0;
      jump_target_id     = '0;
      redirect_ex        = 1'b0;
      redirect_target_ex = '0;
      halt_req           = 1'b0;

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_pc", pc, 32'h0);
         chk("rst_ifid_flush", {31'b0, if_id_flush}, 32'd1);
         chk("rst_idex_flush", {31'b0, id_ex_flush}, 32'd1);
         chk("rst_ifid_write", {31'b0, if_id_write}, 32'd0);
         chk("rst_halted", {31'b0, halted}, 32'd0);
         chk("rst_misalign", {31'b0, misalign}, 32'd0);
      end

      // BOOT cycle
      rst = 1'b1;
      settle();
      chk("boot_pc", pc, 32'h0);
      chk("boot_ifid_flush", {31'b0, if_id_flush}, 32'd1);
      chk("boot_idex_flush", {31'b0, id_ex_flush}, 32'd0);
      chk("boot_ifid_write", {31'b0, if_id_write}, 32'd0);
      tick();
      chk("run0_pc", pc, 32'h0);
      chk("run0_ifid_write", {31'b0, if_id_write}, 32'd1);
      chk("run0_ifid_flush", {31'b0, if_id_flush}, 32'd0);
      tick();
      chk("seq_pc4", pc, 32'h4);
      tick();
      chk("seq_pc8", pc, 32'h8);
      tick();
      chk("seq_pc12", pc, 32'hC);
      chk("seq_pc_plus4", pc_plus4, 32'h10);

      // Branch over stall
      redir(32'h20);
      chk("br_setup_pc", pc, 32'h20);
      redirect_ex        = 1'b1;
      redirect_target_ex = 32'h100;
      stall_id           = 1'b1;
      settle();
      chk("br_ifid_flush", {31'b0, if_id_flush}, 32'd1);
      chk("br_idex_flush", {31'b0, id_ex_flush}, 32'd1);
      tick();
      redirect_ex = 1'b0;
      stall_id    = 1'b0;
      chk("br_pc", pc, 32'h100);

      // Stall then jump
      redir(32'h40);
      chk("sj_setup_pc", pc, 32'h40);
      stall_id       = 1'b1;
      jump_id        = 1'b1;
      jump_target_id = 32'h80;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("sj_ifid_write", {31'b0, if_id_write}, 32'd0);
         chk("sj_ifid_flush", {31'b0, if_id_flush}, 32'd0);
         tick();
         chk("sj_pc_hold", pc, 32'h40);
      end
      stall_id = 1'b0;
      settle();
      chk("sj_jump_ifid_flush", {31'b0, if_id_flush}, 32'd1);
      chk("sj_jump_idex_flush", {31'b0, id_ex_flush}, 32'd0);
      tick();
      jump_id = 1'b0;
      chk("sj_jump_pc", pc, 32'h80);

      // Memory wait with pending redirect
      redir(32'h10);
      imem_ready = 1'b0;
      settle();
      chk("w_ifid_write", {31'b0, if_id_write}, 32'd0);
      tick();
      chk("w_pc_hold0", pc, 32'h10);
      redir(32'h200);
      chk("w_pc_hold1", pc, 32'h10);
      tick();
      chk("w_pc_hold2", pc, 32'h10);
      imem_ready = 1'b1;
      settle();
      chk("w_pend_ifid_flush", {31'b0, if_id_flush}, 32'd1);
      tick();
      chk("w_pend_pc", pc, 32'h200);
      chk("w_pend_ifid_flush_after", {31'b0, if_id_flush}, 32'd0);
      tick();
      chk("w_after_pc", pc, 32'h204);
      imem_ready = 1'b0;
      tick();
      imem_ready = 1'b1;
      settle();
      chk("w_cleared_flush", {31'b0, if_id_flush}, 32'd0);
      chk("w_cleared_write", {31'b0, if_id_write}, 32'd1);
      tick();
      chk("w_cleared_pc", pc, 32'h208);
      chk("w_misalign_clear", {31'b0, misalign}, 32'd0);

      // Misalign then halt
      redir(32'h103);
      chk("ma_pc", pc, 32'h100);
      chk("ma_flag", {31'b0, misalign}, 32'd1);
      tick();
      chk("ma_seq_pc", pc, 32'h104);
      halt_req = 1'b1;
      settle();
      chk("h_ifid_flush", {31'b0, if_id_flush}, 32'd1);
      chk("h_halted_pre", {31'b0, halted}, 32'd0);
      tick();
      halt_req = 1'b0;
      chk("h_halted", {31'b0, halted}, 32'd1);
      chk("h_pc", pc, 32'h104);
      for (int i = 0; i < 10; i++) begin
         jump_id            = 1'b1;
         jump_target_id     = 32'h500 + 32'(i * 8);
         redirect_ex        = 1'b1;
         redirect_target_ex = 32'h600 + 32'(i * 4);
         imem_ready         = 1'($urandom_range(0, 1));
         settle();
         chk("h_ifid_write", {31'b0, if_id_write}, 32'd0);
         tick();
         chk("h_pc_frozen", pc, 32'h104);
         chk("h_halted_hold", {31'b0, halted}, 32'd1);
      end
      jump_id     = 1'b0;
      redirect_ex = 1'b0;
      imem_ready  = 1'b1;
      rst         = 1'b0;
      tick();
      chk("hr_pc", pc, 32'h0);
      chk("hr_halted", {31'b0, halted}, 32'd0);
      chk("hr_misalign", {31'b0, misalign}, 32'd0);

      // Wrap-around
      rst = 1'b1;
      tick();
      redir(32'hFFFF_FFFC);
      chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", pc_plus4, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_misalign", {31'b0, misalign}, 32'd0);

      // Reset while waiting with a pending redirect discards it
      imem_ready = 1'b0;
      tick();
      redir(32'h300);
      chk("rw_pc_hold", pc, 32'h0);
      rst = 1'b0;
      tick();
      chk("rw_rst_pc", pc, 32'h0);
      rst        = 1'b1;
      imem_ready = 1'b1;
      tick();
      settle();
      chk("rw_run_flush", {31'b0, if_id_flush}, 32'd0);
      chk("rw_run_write", {31'b0, if_id_write}, 32'd1);
      tick();
      chk("rw_pc_seq", pc, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
